// File: rtl/spi_read_ip.sv
// rtl/spi_read_ip.sv - SPI read stage: divider, bit counter, SIPO register and FSM
module spi_read_ip #(
  parameter int Width = 12,
  parameter int CntW  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strr_i,
  input  logic [7:0]       kmax_i,
  input  logic             miso_i,
  output logic             dclk_o,
  output logic             cs_o,
  output logic [Width-1:0] dout_o,
  output logic             eor_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       k_q;
  logic [7:0]       div_q;
  logic [CntW-1:0]  bit_q;
  logic [Width-1:0] sr_q;
  logic             run;
  logic             tick;
  logic             start;

  logic             cs_d;
  logic             dclk_d;
  logic             eor_d;
  logic             busy_d;
  logic             load_d;

  // Divider runs only while the serial clock is being generated
  assign run   = (state == SETUP) || (state == LOW) || (state == HIGH);
  assign tick  = run && (div_q == k_q);
  assign start = (state == IDLE) && strr_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (strr_i) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = LOW;
      LOW:     if (tick) state_nxt = HIGH;
      HIGH: begin
        if (tick) begin
          if (bit_q == CntW'(Width)) state_nxt = DONE;
          else                       state_nxt = LOW;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so that every output is registered
  always_comb begin
    cs_d   = 1'b1;
    dclk_d = 1'b0;
    eor_d  = 1'b0;
    busy_d = 1'b1;
    load_d = 1'b0;
    case (state_nxt)
      IDLE:  busy_d = 1'b0;
      SETUP: cs_d   = 1'b0;
      LOW:   cs_d   = 1'b0;
      HIGH: begin
        cs_d   = 1'b0;
        dclk_d = 1'b1;
      end
      DONE: begin
        eor_d  = 1'b1;
        load_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // Output registers; the result word only changes on entry to DONE
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cs_o   <= 1'b1;
      dclk_o <= 1'b0;
      eor_o  <= 1'b0;
      busy_o <= 1'b0;
      dout_o <= '0;
    end else begin
      cs_o   <= cs_d;
      dclk_o <= dclk_d;
      eor_o  <= eor_d;
      busy_o <= busy_d;
      if (load_d) dout_o <= sr_q;
    end
  end

  // Half-period divider, held at zero outside the clocking states
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      div_q <= 8'd0;
    end else if (!run || tick) begin
      div_q <= 8'd0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  // Divider limit is frozen at start so mid-read changes have no effect
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      k_q <= 8'd0;
    end else if (start) begin
      k_q <= kmax_i;
    end
  end

  // Bit counter counts dclk rising edges within a transaction
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bit_q <= '0;
    end else if (start) begin
      bit_q <= '0;
    end else if ((state == LOW) && tick) begin
      bit_q <= bit_q + 1'b1;
    end
  end

  // MSB-first shift register, sampled on the edge where dclk rises
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sr_q <= '0;
    end else if ((state == LOW) && tick) begin
      sr_q <= {sr_q[Width-2:0], miso_i};
    end
  end

endmodule

// File: tb/tb_spi_read_ip.sv
// tb/tb_spi_read_ip.sv - self-checking bench for spi_read_ip
module tb_spi_read_ip;

  localparam int W = 12;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         strr_i;
  logic [7:0]   kmax_i;
  logic         miso_i;
  logic         dclk_o;
  logic         cs_o;
  logic [W-1:0] dout_o;
  logic         eor_o;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] d;
    int           k;
    int           lat;
  } exp_t;

  typedef struct {
    int           kmax;
    logic [W-1:0] data;
    logic [W-1:0] exp_dout;
    int           exp_lat;
  } vec_t;

  exp_t         exp_q[$];
  logic [W-1:0] adc_q[$];

  logic         adc_miso = 1'b0;
  logic         rnd_miso = 1'b0;
  logic [W-1:0] adc_word = '0;
  int           adc_idx  = 0;

  int   cyc = 0;
  logic pb = 1'b0;
  logic pd = 1'b0;
  logic in_txn = 1'b0;
  int   start_cyc = 0;
  int   last_rise = 0;
  int   rises = 0;
  int   eor_count = 0;
  exp_t cur;

  always #5 clk_i = ~clk_i;

  assign miso_i = rst_i ? adc_miso : rnd_miso;

  spi_read_ip #(.Width(W), .CntW(5)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .strr_i (strr_i),
    .kmax_i (kmax_i),
    .miso_i (miso_i),
    .dclk_o (dclk_o),
    .cs_o   (cs_o),
    .dout_o (dout_o),
    .eor_o  (eor_o),
    .busy_o (busy_o)
  );

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // ADC model: loads a word when cs falls, shifts out on dclk falling edges
  always @(negedge cs_o) begin
    if (adc_q.size() > 0) adc_word = adc_q.pop_front();
    else                  adc_word = W'($urandom);
    adc_idx  = W - 1;
    adc_miso = adc_word[adc_idx];
  end

  always @(negedge dclk_o) begin
    if (!cs_o && adc_idx > 0) begin
      adc_idx--;
      adc_miso = adc_word[adc_idx];
    end
  end

  // Monitor and scoreboard, sampled on the falling clock edge
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      in_txn = 1'b0;
      pb     = 1'b0;
      pd     = 1'b0;
    end else begin
      if (busy_o && !pb) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_start", 1, 0);
        end else begin
          cur       = exp_q[0];
          in_txn    = 1'b1;
          start_cyc = cyc;
          last_rise = cyc;
          rises     = 0;
        end
      end
      if (in_txn && dclk_o && !pd) begin
        rises++;
        chk(cyc - last_rise == 2 * (cur.k + 1), "dclk_rise_spacing",
            cyc - last_rise, 2 * (cur.k + 1));
        last_rise = cyc;
      end
      if (in_txn && !dclk_o && pd) begin
        chk(cyc - last_rise == cur.k + 1, "dclk_high_phase", cyc - last_rise, cur.k + 1);
      end
      if (eor_o) begin
        eor_count++;
        if (!in_txn) begin
          chk(1'b0, "unexpected_eor", 1, 0);
        end else begin
          void'(exp_q.pop_front());
          chk(dout_o == cur.d, "sb_dout", int'(dout_o), int'(cur.d));
          chk(cyc - start_cyc == cur.lat, "sb_eor_latency", cyc - start_cyc, cur.lat);
          chk(rises == W, "sb_rise_count", rises, W);
          chk(cs_o == 1'b1, "sb_cs_at_eor", int'(cs_o), 1);
          in_txn = 1'b0;
        end
      end
      pb = busy_o;
      pd = dclk_o;
    end
  end

  task automatic push_read(input logic [W-1:0] word, input int k);
    exp_t e;
    e.d   = word;
    e.k   = k;
    e.lat = (2 * W + 1) * (k + 1);
    exp_q.push_back(e);
    adc_q.push_back(word);
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk_i);
    #1;
    kmax_i = 8'(k);
    strr_i = 1'b1;
    @(negedge clk_i);
    #1;
    strr_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 2000) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (n >= 2000) chk(1'b0, name, n, 2000);
  endtask

  task automatic wait_eor_count(input int target, input string name);
    int n;
    n = 0;
    while (eor_count < target && n < 2000) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (n >= 2000) chk(1'b0, name, eor_count, target);
  endtask

  initial begin
    vec_t vecs[5];
    int   base;
    int   cnt;
    int   n;
    exp_t e;

    vecs[0] = '{kmax: 1, data: 12'hA5C, exp_dout: 12'hA5C, exp_lat: 50};
    vecs[1] = '{kmax: 0, data: 12'hFFF, exp_dout: 12'hFFF, exp_lat: 25};
    vecs[2] = '{kmax: 0, data: 12'h001, exp_dout: 12'h001, exp_lat: 25};
    vecs[3] = '{kmax: 2, data: 12'h3C3, exp_dout: 12'h3C3, exp_lat: 75};
    vecs[4] = '{kmax: 5, data: 12'h81E, exp_dout: 12'h81E, exp_lat: 150};

    // Reset with random inputs
    rst_i  = 1'b0;
    strr_i = 1'b0;
    kmax_i = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      strr_i   = 1'($urandom);
      kmax_i   = 8'($urandom);
      rnd_miso = 1'($urandom);
    end
    @(posedge clk_i);
    #1;
    chk(cs_o == 1'b1, "reset_cs", int'(cs_o), 1);
    chk(dclk_o == 1'b0, "reset_dclk", int'(dclk_o), 0);
    chk(dout_o == '0, "reset_dout", int'(dout_o), 0);
    chk(eor_o == 1'b0, "reset_eor", int'(eor_o), 0);
    chk(busy_o == 1'b0, "reset_busy", int'(busy_o), 0);
    @(negedge clk_i);
    strr_i = 1'b0;
    kmax_i = 8'd1;
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Table-driven single reads
    for (int i = 0; i < 5; i++) begin
      base  = eor_count;
      e.d   = vecs[i].data;
      e.k   = vecs[i].kmax;
      e.lat = vecs[i].exp_lat;
      exp_q.push_back(e);
      adc_q.push_back(vecs[i].data);
      pulse_start(vecs[i].kmax);
      wait_idle("table_timeout");
      chk(eor_count == base + 1, "table_eor_count", eor_count - base, 1);
      chk(dout_o == vecs[i].exp_dout, "table_dout", int'(dout_o), int'(vecs[i].exp_dout));
      repeat (3) @(negedge clk_i);
    end

    // Start and kmax changes during a read are ignored
    base = eor_count;
    push_read(12'h5A3, 3);
    pulse_start(3);
    repeat (20) @(negedge clk_i);
    #1;
    strr_i = 1'b1;
    kmax_i = 8'd0;
    @(negedge clk_i);
    #1;
    strr_i = 1'b0;
    wait_idle("ignored_timeout");
    repeat (5) @(negedge clk_i);
    #1;
    chk(eor_count == base + 1, "ignored_eor_count", eor_count - base, 1);
    chk(busy_o == 1'b0, "ignored_no_restart", int'(busy_o), 0);
    chk(dout_o == 12'h5A3, "ignored_dout", int'(dout_o), 12'h5A3);

    // Back-to-back reads with strr held high
    base = eor_count;
    push_read(12'h123, 1);
    push_read(12'h456, 1);
    @(negedge clk_i);
    #1;
    kmax_i = 8'd1;
    strr_i = 1'b1;
    wait_eor_count(base + 1, "b2b_first_timeout");
    cnt = 0;
    while (cs_o && cnt < 10) begin
      cnt++;
      @(negedge clk_i);
      #1;
    end
    chk(cnt == 2, "b2b_cs_high_cycles", cnt, 2);
    strr_i = 1'b0;
    wait_idle("b2b_second_timeout");
    chk(eor_count == base + 2, "b2b_eor_count", eor_count - base, 2);
    chk(dout_o == 12'h456, "b2b_dout", int'(dout_o), 12'h456);
    repeat (3) @(negedge clk_i);

    // Reset asserted after the 5th dclk rising edge
    base = eor_count;
    push_read(12'h7E1, 2);
    pulse_start(2);
    n = 0;
    while (rises < 5 && n < 2000) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (n >= 2000) chk(1'b0, "midreset_wait_timeout", rises, 5);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk(cs_o == 1'b1, "midreset_cs", int'(cs_o), 1);
    chk(dclk_o == 1'b0, "midreset_dclk", int'(dclk_o), 0);
    chk(dout_o == '0, "midreset_dout", int'(dout_o), 0);
    chk(eor_o == 1'b0, "midreset_eor", int'(eor_o), 0);
    chk(busy_o == 1'b0, "midreset_busy", int'(busy_o), 0);
    void'(exp_q.pop_front());
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    #1;
    chk(eor_count == base, "midreset_no_eor", eor_count - base, 0);

    push_read(12'h3C3, 2);
    pulse_start(2);
    wait_idle("post_reset_timeout");
    chk(eor_count == base + 1, "post_reset_eor_count", eor_count - base, 1);
    chk(dout_o == 12'h3C3, "post_reset_dout", int'(dout_o), 12'h3C3);
    repeat (3) @(negedge clk_i);
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
